// File: rtl/colparity_ctrl.sv
// ---------------------------------------------------------------------------
// colparity_ctrl
//
// Sequencing FSM for the slice-serial column-parity (theta) datapath.
// The state is held as SLICES slice words of 25 bits each. This block holds
// no data bits. It steps the slice memory through four phases:
//   LOAD    : write matrixIn into slices 0..SLICES-1
//   PRIME   : read the last slice so that slice 0 sees its z-1 neighbour
//   COMPUTE : read-modify-write every slice with the theta result
//   OUTPUT  : present every slice to the matrixOut register
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request a new state (sampled only in IDLE)
//   ready      high in IDLE
//   putInput   high during the SLICES LOAD cycles
//   outReady   high during the SLICES OUTPUT cycles
//   memAddr    slice memory address (async read, sync write)
//   memWe      slice memory write enable
//   memSrcSel  write data source: 0 = matrixIn, 1 = theta result
//   prevLd     load previous-slice parity register from current read slice
//   outLd      load matrixOut register from memory read data
//   done       one-cycle pulse on the last OUTPUT cycle
//
// Build option
//   COLPARITY_CTRL_STREAM_EN : when defined, start on the last OUTPUT cycle
//   goes straight to LOAD, skipping IDLE, so states run back to back.
//
// All outputs are registered. They are decoded from the next state and the
// next count, so each output is the Moore function of the current state and
// count, with no combinational path to the pins.
// ---------------------------------------------------------------------------
module colparity_ctrl #(
    parameter int SLICES = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    output logic              putInput,
    output logic              outReady,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic              memSrcSel,
    output logic              prevLd,
    output logic              outLd,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PRIME   = 3'd2,
        S_COMPUTE = 3'd3,
        S_OUTPUT  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(SLICES - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic              last_s;

    logic              ready_nxt_s;
    logic              put_input_nxt_s;
    logic              out_ready_nxt_s;
    logic [ADDR_W-1:0] mem_addr_nxt_s;
    logic              mem_we_nxt_s;
    logic              mem_src_sel_nxt_s;
    logic              prev_ld_nxt_s;
    logic              out_ld_nxt_s;
    logic              done_nxt_s;

    assign last_s = (cnt_r == CNT_LAST);

    // State and slice counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and next-count logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_LOAD;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            S_LOAD: begin
                if (last_s) begin
                    state_nxt_s = S_PRIME;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            S_PRIME: begin
                // Single cycle: the wrap-around parity is now captured.
                state_nxt_s = S_COMPUTE;
                cnt_nxt_s   = CNT_ZERO;
            end
            S_COMPUTE: begin
                if (last_s) begin
                    state_nxt_s = S_OUTPUT;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            S_OUTPUT: begin
                if (last_s) begin
                    cnt_nxt_s = CNT_ZERO;
`ifdef COLPARITY_CTRL_STREAM_EN
                    if (start) begin
                        state_nxt_s = S_LOAD;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
`else
                    state_nxt_s = S_IDLE;
`endif
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Decode the outputs for the state and count about to be entered.
    always_comb begin
        ready_nxt_s       = 1'b0;
        put_input_nxt_s   = 1'b0;
        out_ready_nxt_s   = 1'b0;
        mem_addr_nxt_s    = cnt_nxt_s;
        mem_we_nxt_s      = 1'b0;
        mem_src_sel_nxt_s = 1'b0;
        prev_ld_nxt_s     = 1'b0;
        out_ld_nxt_s      = 1'b0;
        done_nxt_s        = 1'b0;
        case (state_nxt_s)
            S_IDLE: begin
                ready_nxt_s = 1'b1;
            end
            S_LOAD: begin
                put_input_nxt_s = 1'b1;
                mem_we_nxt_s    = 1'b1;
            end
            S_PRIME: begin
                // Read the last slice so slice 0 gets its z-1 neighbour.
                mem_addr_nxt_s = CNT_LAST;
                prev_ld_nxt_s  = 1'b1;
            end
            S_COMPUTE: begin
                // Read old slice, write theta result at the same address;
                // parity for the next slice comes from the pre-write data.
                mem_we_nxt_s      = 1'b1;
                mem_src_sel_nxt_s = 1'b1;
                prev_ld_nxt_s     = 1'b1;
            end
            S_OUTPUT: begin
                out_ready_nxt_s = 1'b1;
                out_ld_nxt_s    = 1'b1;
                done_nxt_s      = (cnt_nxt_s == CNT_LAST);
            end
            default: begin
                mem_addr_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // Output registers; reset leaves the block presenting the IDLE outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready     <= 1'b1;
            putInput  <= 1'b0;
            outReady  <= 1'b0;
            memAddr   <= CNT_ZERO;
            memWe     <= 1'b0;
            memSrcSel <= 1'b0;
            prevLd    <= 1'b0;
            outLd     <= 1'b0;
            done      <= 1'b0;
        end else begin
            ready     <= ready_nxt_s;
            putInput  <= put_input_nxt_s;
            outReady  <= out_ready_nxt_s;
            memAddr   <= mem_addr_nxt_s;
            memWe     <= mem_we_nxt_s;
            memSrcSel <= mem_src_sel_nxt_s;
            prevLd    <= prev_ld_nxt_s;
            outLd     <= out_ld_nxt_s;
            done      <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_colparity_ctrl.sv
// ---------------------------------------------------------------------------
// tb_colparity_ctrl
//
// Directed bench for colparity_ctrl. A table of per-phase records drives the
// full control sequence. A small slice memory and theta datapath run under
// the controller's outputs and are checked against hand-computed slices.
// Hand-written sequences cover asynchronous reset mid-COMPUTE and the
// start-at-last-OUTPUT case.
// ---------------------------------------------------------------------------
module tb_colparity_ctrl;

    localparam int SLICES = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst;
    logic              start;
    logic              ready;
    logic              putInput;
    logic              outReady;
    logic [ADDR_W-1:0] memAddr;
    logic              memWe;
    logic              memSrcSel;
    logic              prevLd;
    logic              outLd;
    logic              done;

    int vectors_applied = 0;
    int miscompares     = 0;

    colparity_ctrl #(.SLICES(SLICES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .putInput  (putInput),
        .outReady  (outReady),
        .memAddr   (memAddr),
        .memWe     (memWe),
        .memSrcSel (memSrcSel),
        .prevLd    (prevLd),
        .outLd     (outLd),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench-side slice datapath ----------------
    logic [24:0] in_slices  [SLICES];
    logic [24:0] exp_slices [SLICES];
    logic [24:0] mem_r      [SLICES];
    logic [4:0]  prev_r;
    logic [24:0] matrix_out_r;
    logic [24:0] rd_s;
    logic [24:0] matrix_in_s;

    assign rd_s        = mem_r[memAddr];
    assign matrix_in_s = in_slices[memAddr];

    function automatic logic [4:0] col_par(input logic [24:0] s);
        logic [4:0] p;
        for (int x = 0; x < 5; x++)
            p[x] = s[x] ^ s[x+5] ^ s[x+10] ^ s[x+15] ^ s[x+20];
        return p;
    endfunction

    function automatic logic [24:0] theta_slice(input logic [24:0] s, input logic [4:0] prev);
        logic [24:0] r;
        logic [4:0]  c;
        c = col_par(s);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[x+5*y] = s[x+5*y] ^ c[(x+4)%5] ^ prev[(x+1)%5];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (memWe) mem_r[memAddr] <= memSrcSel ? theta_slice(rd_s, prev_r) : matrix_in_s;
        if (prevLd) prev_r <= col_par(rd_s);
        if (outLd) matrix_out_r <= rd_s;
    end

    // ---------------- comparison helpers ----------------
    // Packed as {ready,putInput,outReady,memWe,memSrcSel,prevLd,outLd,done,memAddr}
    localparam logic [13:0] RST_EXP  = {1'b1, 7'b0000000, 6'd0};
    localparam logic [13:0] LOAD0_EXP = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};

    task automatic check_ctrl(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {ready, putInput, outReady, memWe, memSrcSel, prevLd, outLd, done, memAddr};
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got rdy/put/ordy/we/src/prev/old/done=%b addr=%0d, wanted %b addr=%0d",
                     name, act[13:6], act[5:0], exp[13:6], exp[5:0]);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // ---------------- control sequence table ----------------
    typedef struct {
        logic start;
        int   n;
        logic ready, put_input, out_ready, mem_we, mem_src_sel, prev_ld, out_ld, done;
        int   addr0;
        int   addr_inc;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [13:0] vec_exp(input vec_t v, input int k);
        logic [5:0] a;
        a = 6'(v.addr0 + k * v.addr_inc);
        return {v.ready, v.put_input, v.out_ready, v.mem_we, v.mem_src_sel,
                v.prev_ld, v.out_ld, v.done, a};
    endfunction

    // One state through the theta datapath; a single bit at (0,0,zsrc).
    task automatic run_theta(input int zsrc);
        int c;
        for (int z = 0; z < SLICES; z++) begin
            in_slices[z]  = 25'h0;
            exp_slices[z] = 25'h0;
        end
        in_slices[zsrc]                = 25'h0000001;
        exp_slices[zsrc]               = 25'h0210843;  // own bit + column x=1 in all rows
        exp_slices[(zsrc + 1) % SLICES] = 25'h1084210; // column x=4 in all rows
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!outReady && c < 400) begin
            @(negedge clk);
            c++;
        end
        check_val($sformatf("latency_z%0d", zsrc), c, 32'd129);
        for (int i = 0; i < SLICES; i++) begin
            @(negedge clk);
            check_val($sformatf("slice_z%0d_%0d", zsrc, i), {7'b0, matrix_out_r}, {7'b0, exp_slices[i]});
        end
        check_val($sformatf("ready_after_z%0d", zsrc), {31'b0, ready}, 32'd1);
    endtask

    initial begin
        int c;
        int load_cnt;

        vecs[0] = '{1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0}; // idle
        vecs[1] = '{1'b1,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0}; // start
        vecs[2] = '{1'b1, 64, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  0, 1}; // load
        vecs[3] = '{1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 63, 0}; // prime
        vecs[4] = '{1'b1, 64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  0, 1}; // compute
        vecs[5] = '{1'b0, 63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  0, 1}; // output
        vecs[6] = '{1'b0,  1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 63, 0}; // last output
        vecs[7] = '{1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0}; // idle again

        for (int z = 0; z < SLICES; z++) in_slices[z] = 25'h0;

        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_ctrl("reset", RST_EXP);
        rst = 1'b0;
        @(negedge clk);

        // Full control sequence, start held high through LOAD..COMPUTE.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                check_ctrl($sformatf("seq%0d_%0d", i, k), vec_exp(vecs[i], k));
                start = vecs[i].start;
                @(negedge clk);
            end
        end
        start = 1'b0;

        // Datapath integration, including the slice 63 -> slice 0 wrap.
        run_theta(0);
        run_theta(63);

        // Asynchronous reset in the middle of COMPUTE.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (85) @(negedge clk);
        check_ctrl("compute_cnt20", {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd20});
        #2 rst = 1'b1;
        #1 check_ctrl("async_reset", RST_EXP);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_ctrl("idle_after_reset", RST_EXP);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_cnt = 0;
        for (int k = 0; k < 70; k++) begin
            if (putInput) begin
                check_val("reload_addr", {26'b0, memAddr}, load_cnt);
                load_cnt++;
            end
            @(negedge clk);
        end
        check_val("reload_len", load_cnt, 32'd64);
        c = 0;
        while (!ready && c < 300) begin
            @(negedge clk);
            c++;
        end
        check_val("ready_return", {31'b0, ready}, 32'd1);

        // Start held high for a whole run, still high on the last OUTPUT cycle.
        start = 1'b1;
        @(negedge clk);
        c = 0;
        while (!done && c < 400) begin
            @(negedge clk);
            c++;
        end
        check_val("done_seen", {31'b0, done}, 32'd1);
        check_val("done_after", c, 32'd192);
        check_val("ready_at_done", {31'b0, ready}, 32'd0);
        @(negedge clk);
`ifdef COLPARITY_CTRL_STREAM_EN
        check_ctrl("stream_load", LOAD0_EXP);
`else
        check_ctrl("idle_after_output", RST_EXP);
        @(negedge clk);
        check_ctrl("load_after_idle", LOAD0_EXP);
`endif
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
